// File: rtl/button_event_arbiter.sv
// button_event_arbiter
// Turns N synchronous button levels into tap / auto-repeat events and
// serialises them onto one valid/ready command port. Buttons are served
// round-robin, and all outputs are registered.

module button_event_arbiter #(
    parameter  int N_BTN         = 4,
    parameter  int HOLD_CYCLES   = 25000000,
    parameter  int REPEAT_CYCLES = 6250000,
    localparam int MAX_CYC       = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES,
    localparam int CNT_W         = $clog2(MAX_CYC),
    localparam int ID_W          = ($clog2(N_BTN) > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             cmd_ready,
    input  logic             clr_overflow,
    output logic             cmd_valid,
    output logic [ID_W-1:0]  cmd_id,
    output logic             cmd_repeat,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRESS  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       state [N_BTN];
    logic [CNT_W-1:0] cnt   [N_BTN];

    logic [N_BTN-1:0] ev;           // event emitted by button i this cycle
    logic [N_BTN-1:0] ev_rep;       // type of that event: 1 = repeat
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] pending_rep;
    logic [N_BTN-1:0] granted;      // one-hot grant, zero when no grant
    logic [N_BTN-1:0] drop;         // new event lost to an ungranted pending one

    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  grant;
    logic             grant_found;
    logic             out_free;

    // Decode tap / repeat events from each button's current state and input.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a bit unassigned, which would otherwise infer a latch.
        ev     = '0;
        ev_rep = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (state[i])
                ST_PRESS: begin
                    if (!btn_in[i]) begin
                        ev[i] = 1'b1;
                    end else if (cnt[i] == HOLD_LAST) begin
                        ev[i]     = 1'b1;
                        ev_rep[i] = 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (btn_in[i] && cnt[i] == REP_LAST) begin
                        ev[i]     = 1'b1;
                        ev_rep[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-button press/hold state machine and its hold/repeat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the per-button arrays are plain flops (not a RAM), so they
            // are reset element by element; a released button must not carry
            // stale state across a reset.
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= ST_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        if (btn_in[i]) begin
                            state[i] <= ST_PRESS;
                            cnt[i]   <= '0;
                        end
                    end
                    ST_PRESS: begin
                        if (!btn_in[i]) begin
                            state[i] <= ST_IDLE;
                        end else if (cnt[i] == HOLD_LAST) begin
                            state[i] <= ST_REPEAT;
                            cnt[i]   <= '0;
                        end else begin
                            // NOTE: sequential state always uses <= so every
                            // flop samples the pre-edge values of its inputs.
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!btn_in[i]) begin
                            state[i] <= ST_IDLE;   // release after hold: no tap
                        end else if (cnt[i] == REP_LAST) begin
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i] <= ST_IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Round-robin pick: the first pending button after the last one granted.
    always_comb begin
        int idx;
        out_free    = !cmd_valid || cmd_ready;
        grant       = '0;
        grant_found = 1'b0;
        granted     = '0;
        idx         = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(last) + k) % N_BTN;
            if (!grant_found && pending[idx]) begin
                grant_found = 1'b1;
                grant       = ID_W'(idx);
            end
        end
        if (out_free && grant_found) begin
            granted[grant] = 1'b1;
        end
        drop = ev & pending & ~granted;
    end

    // Capture events into the pending flags; a new event beats a same-edge grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            pending_rep <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (ev[i] && !drop[i]) begin
                    pending[i]     <= 1'b1;
                    pending_rep[i] <= ev_rep[i];
                end else if (granted[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Output register: load the granted command whenever the slot is free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_valid  <= 1'b0;
            cmd_id     <= '0;
            cmd_repeat <= 1'b0;
            last       <= ID_W'(N_BTN - 1);
        end else if (out_free) begin
            if (grant_found) begin
                cmd_valid  <= 1'b1;
                cmd_id     <= grant;
                cmd_repeat <= pending_rep[grant];
                last       <= grant;
            end else begin
                cmd_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow flag; a drop on the same edge overrides the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (|drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (N_BTN=4, HOLD=8, REPEAT=4).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic       cmd_ready;
    logic       clr_overflow;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       cmd_repeat;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    button_event_arbiter #(
        .N_BTN         (4),
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .cmd_ready    (cmd_ready),
        .clr_overflow (clr_overflow),
        .cmd_valid    (cmd_valid),
        .cmd_id       (cmd_id),
        .cmd_repeat   (cmd_repeat),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        btn_in       = '0;
        cmd_ready    = 1'b1;
        clr_overflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One-cycle press of button idx followed by the release sample.
    task automatic tap(input int idx);
        btn_in[idx] = 1'b1;
        step();
        btn_in[idx] = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_in = '0; cmd_ready = 1'b1; clr_overflow = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || cmd_id !== 2'd0 || cmd_repeat !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b id=%0d rep=%b ovf=%b expected all 0",
                     cmd_valid, cmd_id, cmd_repeat, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_tap();
        do_reset();
        btn_in[2] = 1'b1;
        step(); step(); step();
        btn_in[2] = 1'b0;
        step();                       // first low sample: pending set
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL tap_early: got v=%b expected v=0", cmd_valid);
        end
        step();                       // second edge: command loaded
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || cmd_repeat !== 1'b0) begin
            errors++;
            $display("FAIL tap_cmd: got v=%b id=%0d rep=%b expected v=1 id=2 rep=0",
                     cmd_valid, cmd_id, cmd_repeat);
        end
        step();
        checks++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL tap_single: got v=%b ovf=%b expected v=0 ovf=0", cmd_valid, overflow);
        end
    endtask

    task automatic test_hold();
        int n_cmd;
        n_cmd = 0;
        do_reset();
        btn_in[1] = 1'b1;
        for (int e = 0; e < 20; e++) begin
            logic exp_v;
            step();
            exp_v = (e == 9 || e == 13 || e == 17);
            if (cmd_valid === 1'b1) n_cmd++;
            checks++;
            if (cmd_valid !== exp_v || (exp_v && (cmd_id !== 2'd1 || cmd_repeat !== 1'b1))) begin
                errors++;
                $display("FAIL hold_edge%0d: got v=%b id=%0d rep=%b expected v=%b id=1 rep=1",
                         e, cmd_valid, cmd_id, cmd_repeat, exp_v);
            end
        end
        btn_in[1] = 1'b0;
        for (int e = 20; e < 24; e++) begin
            step();
            if (cmd_valid === 1'b1) n_cmd++;
        end
        checks++;
        if (n_cmd !== 3) begin
            errors++;
            $display("FAIL hold_count: got %0d commands expected 3 (no tap on release)", n_cmd);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_a [3];
        logic [1:0] exp_b [2];
        exp_a[0] = 2'd0; exp_a[1] = 2'd1; exp_a[2] = 2'd3;
        exp_b[0] = 2'd0; exp_b[1] = 2'd3;
        do_reset();
        btn_in = 4'b1011;
        step();
        btn_in = 4'b0000;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_id !== exp_a[k] || cmd_repeat !== 1'b0) begin
                errors++;
                $display("FAIL rr_a%0d: got v=%b id=%0d rep=%b expected v=1 id=%0d rep=0",
                         k, cmd_valid, cmd_id, cmd_repeat, exp_a[k]);
            end
        end
        btn_in = 4'b1001;
        step();
        btn_in = 4'b0000;
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_id !== exp_b[k]) begin
                errors++;
                $display("FAIL rr_wrap%0d: got v=%b id=%0d expected v=1 id=%0d",
                         k, cmd_valid, cmd_id, exp_b[k]);
            end
        end
        step();
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got v=%b expected v=0", cmd_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cmd_ready = 1'b0;
        tap(0);
        step();                       // first tap loaded, held by !ready
        tap(0);                       // second tap stays pending
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v=%b id=%0d ovf=%b expected v=1 id=0 ovf=0",
                     cmd_valid, cmd_id, overflow);
        end
        tap(0);                       // third tap dropped
        checks++;
        if (overflow !== 1'b1 || cmd_valid !== 1'b1 || cmd_id !== 2'd0) begin
            errors++;
            $display("FAIL bp_overflow: got v=%b id=%0d ovf=%b expected v=1 id=0 ovf=1",
                     cmd_valid, cmd_id, overflow);
        end
        cmd_ready = 1'b1;
        step();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd0 || cmd_repeat !== 1'b0) begin
            errors++;
            $display("FAIL bp_second: got v=%b id=%0d rep=%b expected v=1 id=0 rep=0",
                     cmd_valid, cmd_id, cmd_repeat);
        end
        step();
        checks++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: got v=%b ovf=%b expected v=0 ovf=1", cmd_valid, overflow);
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_clear: got ovf=%b expected 0", overflow);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cmd_ready = 1'b0;
        tap(0);
        step();                       // id 0 parked on the output
        tap(2);                       // pending[2] waits behind it
        btn_in[2] = 1'b1;
        step();                       // btn 2 pressed again
        btn_in[2] = 1'b0;
        cmd_ready = 1'b1;
        step();                       // grant of 2 and new tap of 2 on one edge
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL sim_first: got v=%b id=%0d ovf=%b expected v=1 id=2 ovf=0",
                     cmd_valid, cmd_id, overflow);
        end
        step();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || cmd_repeat !== 1'b0) begin
            errors++;
            $display("FAIL sim_second: got v=%b id=%0d rep=%b expected v=1 id=2 rep=0",
                     cmd_valid, cmd_id, cmd_repeat);
        end
        step();
        checks++;
        if (cmd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL sim_end: got v=%b ovf=%b expected v=0 ovf=0", cmd_valid, overflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cmd_ready = 1'b0;
        tap(0);
        step();
        tap(0);
        tap(0);                       // overflow now set
        cmd_ready = 1'b1;
        step();
        step();
        btn_in[3] = 1'b1;
        for (int e = 0; e < 10; e++) step();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd3 || cmd_repeat !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: got v=%b id=%0d rep=%b ovf=%b expected v=1 id=3 rep=1 ovf=1",
                     cmd_valid, cmd_id, cmd_repeat, overflow);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_repeat !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ar_async: got v=%b rep=%b ovf=%b expected all 0 before edge",
                     cmd_valid, cmd_repeat, overflow);
        end
        #1 reset = 1'b0;
        for (int e = 0; e < 10; e++) begin
            logic exp_v;
            step();
            exp_v = (e == 9);
            checks++;
            if (cmd_valid !== exp_v || (exp_v && (cmd_id !== 2'd3 || cmd_repeat !== 1'b1))) begin
                errors++;
                $display("FAIL ar_rehold%0d: got v=%b id=%0d rep=%b expected v=%b id=3 rep=1",
                         e, cmd_valid, cmd_id, cmd_repeat, exp_v);
            end
        end
        btn_in = '0;
    endtask

    initial begin
        test_reset();
        test_tap();
        test_hold();
        test_round_robin();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
